// File: rtl/dmem_bank_sram.sv
// Data-memory bank for the core's dat_* port: byte-lane writes, per-lane read hold,
// configurable read latency and an optional post-reset zero-fill sequencer.
module dmem_bank_sram #(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 32,
   parameter int unsigned DEPTH_LOG2 = 14,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned INIT_ZERO  = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [AW-1:0]       dat_a,
   input  logic [(DW/8)-1:0]   dat_we,
   input  logic [DW-1:0]       dat_wd,
   input  logic [(DW/8)-1:0]   dat_re,
   output logic [DW-1:0]       dat_rd,
   output logic                rd_vld,
   output logic                busy,
   output logic                drop
);

   localparam int unsigned NB    = DW / 8;
   localparam int unsigned OB    = $clog2(NB);
   localparam int unsigned IW    = DEPTH_LOG2;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   cnt, cnt_nx;
   logic            clr_we_c;

   logic            req_c;
   logic [IW-1:0]   idx_q;
   logic [NB-1:0]   we_q;
   logic [NB-1:0]   re_q;
   logic [DW-1:0]   wd_q;
   logic            drop_q;

   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   rd_word_c;
   logic [DW-1:0]   fin_data;
   logic [NB-1:0]   fin_re;
   logic [DW-1:0]   hold_q;

   // Offset and alias bits of the address are intentionally ignored.
   logic [AW-1:0]   unused_addr;
   assign unused_addr = dat_a;

   // Clear sequencer state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= (INIT_ZERO != 0) ? CLEAR : READY;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Clear sequencer next state: zero one word per cycle, then hand over.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr_we_c = 1'b0;
      case (state)
         CLEAR: begin
            clr_we_c = 1'b1;
            cnt_nx   = cnt + IW'(1);
            if (cnt == IW'(DEPTH - 1)) begin
               state_nx = READY;
            end
         end
         READY: begin
            state_nx = READY;
         end
         default: begin
            state_nx = READY;
         end
      endcase
   end

   assign busy  = (state == CLEAR);
   assign req_c = (|dat_we) | (|dat_re);

   // Request capture; requests seen while clearing are discarded and flagged.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q  <= '0;
         we_q   <= '0;
         re_q   <= '0;
         wd_q   <= '0;
         drop_q <= 1'b0;
      end else begin
         drop_q <= busy & req_c;
         if (!busy && req_c) begin
            idx_q <= dat_a[IW+OB-1:OB];
            we_q  <= dat_we;
            re_q  <= dat_re;
            wd_q  <= dat_wd;
         end else begin
            we_q  <= '0;
            re_q  <= '0;
         end
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         mem[cnt] <= '0;
      end else begin
         for (int k = 0; k < int'(NB); k++) begin
            if (we_q[k]) begin
               mem[idx_q][8*k +: 8] <= wd_q[8*k +: 8];
            end
         end
      end
   end

   // Write-first read: lanes being written this cycle bypass the array.
   always_comb begin
      rd_word_c = mem[idx_q];
      for (int k = 0; k < int'(NB); k++) begin
         if (we_q[k]) begin
            rd_word_c[8*k +: 8] = wd_q[8*k +: 8];
         end
      end
   end

   generate
      if (RD_LAT > 1) begin : g_pipe
         localparam int unsigned PL = RD_LAT - 1;
         logic [DW-1:0] p_data [PL];
         logic [NB-1:0] p_re   [PL];

         // Extra output stages; the lane mask travels with the data.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < int'(PL); i++) begin
                  p_data[i] <= '0;
                  p_re[i]   <= '0;
               end
            end else begin
               p_data[0] <= rd_word_c;
               p_re[0]   <= re_q;
               for (int i = 1; i < int'(PL); i++) begin
                  p_data[i] <= p_data[i-1];
                  p_re[i]   <= p_re[i-1];
               end
            end
         end

         assign fin_data = p_data[PL-1];
         assign fin_re   = p_re[PL-1];
      end else begin : g_nopipe
         assign fin_data = rd_word_c;
         assign fin_re   = re_q;
      end
   endgenerate

   // Unread lanes keep their last value.
   always_comb begin
      dat_rd = hold_q;
      for (int k = 0; k < int'(NB); k++) begin
         if (fin_re[k]) begin
            dat_rd[8*k +: 8] = fin_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q <= '0;
      end else begin
         hold_q <= dat_rd;
      end
   end

   assign rd_vld = |fin_re;
   assign drop   = drop_q;

endmodule

// File: tb/tb_dmem_bank_sram.sv
// Bench for dmem_bank_sram: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// checked every cycle against a transaction-level memory model.
module tb_dmem_bank_sram;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] dat_a = '0;
   logic [3:0]  dat_we = '0;
   logic [31:0] dat_wd = '0;
   logic [3:0]  dat_re = '0;
   logic [31:0] rd0, rd1;
   logic        vld0, vld1, busy0, busy1, drop0, drop1;

   int errors = 0;
   int checks = 0;
   logic run = 1'b0;

   always #5 clk = ~clk;

   dmem_bank_sram #(.AW(16), .DW(32), .DEPTH_LOG2(4), .RD_LAT(1), .INIT_ZERO(1)) u_lat1 (
      .clk(clk), .rstn(rstn), .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
      .dat_re(dat_re), .dat_rd(rd0), .rd_vld(vld0), .busy(busy0), .drop(drop0));

   dmem_bank_sram #(.AW(16), .DW(32), .DEPTH_LOG2(4), .RD_LAT(3), .INIT_ZERO(1)) u_lat3 (
      .clk(clk), .rstn(rstn), .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
      .dat_re(dat_re), .dat_rd(rd1), .rd_vld(vld1), .busy(busy1), .drop(drop1));

   // Model: a word array, a busy countdown and per-instance delivery slots by edge number.
   logic [31:0] m_mem [16];
   int          m_busy_left;
   logic        m_drop;
   logic [31:0] m_held;
   int          m_edge = 0;
   logic        m_slot_v [2][8];
   logic [31:0] m_slot_d [2][8];
   logic        m_vld [2];
   logic [31:0] m_rd [2];

   function automatic int lat_of(input int j);
      return (j == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy_left = 16;
      m_drop      = 1'b0;
      m_held      = '0;
      for (int j = 0; j < 2; j++) begin
         m_vld[j] = 1'b0;
         m_rd[j]  = '0;
         for (int s = 0; s < 8; s++) begin
            m_slot_v[j][s] = 1'b0;
            m_slot_d[j][s] = '0;
         end
      end
   endtask

   task automatic model_step();
      int  idx;
      int  s;
      logic req;
      m_edge++;
      m_drop = 1'b0;
      req = (dat_we != 4'd0) || (dat_re != 4'd0);
      if (m_busy_left > 0) begin
         m_drop = req;
         m_busy_left--;
         if (m_busy_left == 0) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
         end
      end else if (req) begin
         idx = (int'(dat_a) / 4) % 16;
         for (int k = 0; k < 4; k++) begin
            if (dat_we[k]) m_mem[idx][8*k +: 8] = dat_wd[8*k +: 8];
         end
         if (dat_re != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
               if (dat_re[k]) m_held[8*k +: 8] = m_mem[idx][8*k +: 8];
            end
            for (int j = 0; j < 2; j++) begin
               s = (m_edge + lat_of(j) - 1) % 8;
               m_slot_v[j][s] = 1'b1;
               m_slot_d[j][s] = m_held;
            end
         end
      end
      for (int j = 0; j < 2; j++) begin
         s = m_edge % 8;
         m_vld[j] = m_slot_v[j][s];
         if (m_slot_v[j][s]) m_rd[j] = m_slot_d[j][s];
         m_slot_v[j][s] = 1'b0;
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (run) begin
         chk("busy_l1", 32'(busy0), 32'(m_busy_left > 0));
         chk("busy_l3", 32'(busy1), 32'(m_busy_left > 0));
         chk("drop_l1", 32'(drop0), 32'(m_drop));
         chk("drop_l3", 32'(drop1), 32'(m_drop));
         chk("vld_l1", 32'(vld0), 32'(m_vld[0]));
         chk("vld_l3", 32'(vld1), 32'(m_vld[1]));
         chk("rd_l1", rd0, m_rd[0]);
         chk("rd_l3", rd1, m_rd[1]);
      end
   end

   task automatic step(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
      dat_a  = a;
      dat_we = we;
      dat_wd = wd;
      dat_re = re;
      @(posedge clk);
      if (rstn) model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(16'h0, 4'h0, 32'h0, 4'h0);
   endtask

   task automatic do_reset();
      rstn   = 1'b0;
      dat_a  = '0;
      dat_we = '0;
      dat_wd = '0;
      dat_re = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy0 && n < 40) begin
         idle(1);
         n++;
      end
   endtask

   initial begin
      int n;
      do_reset();
      run = 1'b1;
      chk("rst_busy", 32'(busy0), 32'd1);
      chk("rst_vld", 32'(vld0), 32'd0);
      chk("rst_rd", rd1, 32'h0);
      chk("rst_drop", 32'(drop0), 32'd0);
      count_busy(n);
      chk("busy_cycles", 32'(n), 32'd16);

      for (int i = 0; i < 16; i++) begin
         step(16'(i * 4), 4'h0, 32'h0, 4'hF);
         chk("clr_vld", 32'(vld0), 32'd1);
         chk("clr_rd", rd0, 32'h0);
      end

      step(16'h0028, 4'hF, 32'hDEADBEEF, 4'h0);
      step(16'h0028, 4'b0010, 32'h00005500, 4'h0);
      step(16'h0028, 4'h0, 32'h0, 4'hF);
      chk("lane_merge", rd0, 32'hDEAD55EF);

      step(16'h0018, 4'hF, 32'h11223344, 4'h0);
      step(16'h001C, 4'hF, 32'h000000AA, 4'h0);
      step(16'h0018, 4'h0, 32'h0, 4'hF);
      chk("full_read", rd0, 32'h11223344);
      step(16'h001C, 4'h0, 32'h0, 4'b0001);
      chk("lane_hold", rd0, 32'h112233AA);

      step(16'h0004, 4'hF, 32'h01010101, 4'h0);
      step(16'h0008, 4'hF, 32'h02020202, 4'h0);
      step(16'h000C, 4'hF, 32'h03030303, 4'h0);
      step(16'h0004, 4'h0, 32'h0, 4'hF);
      step(16'h0008, 4'h0, 32'h0, 4'hF);
      step(16'h000C, 4'h0, 32'h0, 4'hF);
      chk("lat3_vld0", 32'(vld1), 32'd1);
      chk("lat3_w1", rd1, 32'h01010101);
      idle(1);
      chk("lat3_w2", rd1, 32'h02020202);
      idle(1);
      chk("lat3_w3", rd1, 32'h03030303);
      chk("lat3_vld2", 32'(vld1), 32'd1);
      idle(1);
      chk("lat3_end", 32'(vld1), 32'd0);

      step(16'h0010, 4'hF, 32'hCAFEF00D, 4'hF);
      chk("wr_first", rd0, 32'hCAFEF00D);
      step(16'h0048, 4'h0, 32'h0, 4'hF);
      chk("alias", rd0, 32'h02020202);

      step(16'h0028, 4'h0, 32'h0, 4'hF);
      do_reset();
      chk("rst_inflight", 32'(vld1), 32'd0);
      chk("rst_rd3", rd1, 32'h0);

      idle(5);
      step(16'h0000, 4'hF, 32'hFFFFFFFF, 4'hF);
      chk("drop_pulse", 32'(drop0), 32'd1);
      chk("drop_novld", 32'(vld0), 32'd0);
      idle(1);
      chk("drop_once", 32'(drop0), 32'd0);
      idle(2);
      do_reset();
      count_busy(n);
      chk("busy_restart", 32'(n), 32'd16);
      step(16'h0000, 4'h0, 32'h0, 4'hF);
      chk("drop_nowrite", rd0, 32'h0);
      chk("drop_vld", 32'(vld0), 32'd1);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
